// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
//
// Contents:
//   FETCH_DATA_W  default instruction word width
//   FETCH_DEPTH   default number of words in the instruction image
//   HALT_WORD     instruction value that terminates issue
//   state_t       sequencer states {S_IDLE, S_ISSUE, S_DONE}

package fetch_pkg;

    localparam int FETCH_DATA_W = 32;
    localparam int FETCH_DEPTH  = 8;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ins_buffer.sv
// rtl/ins_buffer.sv - snapshot register file holding the instruction image
//
// Ports:
//   clk      in   system clock
//   load     in   capture every word of im_flat on this edge
//   im_flat  in   DEPTH*DATA_W image, word i at [i*DATA_W +: DATA_W]
//   rd_addr  in   word index to read
//   rd_data  out  word at rd_addr (combinational read)
//
// The array carries no reset: its contents are only observed after a load.

module ins_buffer
    import fetch_pkg::*;
#(
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH  = FETCH_DEPTH,
    parameter int PC_W   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    load,
    input  logic [DEPTH*DATA_W-1:0] im_flat,
    input  logic [PC_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]       rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= im_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ins_fetch_seq.sv
// rtl/ins_fetch_seq.sv - issues a snapshotted instruction image one word per handshake
//
// Optional feature macro: FETCH_LOOP_EN
//   defined   : accepting a non-HALT word at the last index wraps pc to 0; only a
//               HALT word ends issue; retired saturates at all-ones.
//   undefined : issue ends at the last word or at a HALT word.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   RST        in   synchronous active-high reset
//   start      in   snapshot image and begin issue (honoured in IDLE/DONE only)
//   im_flat    in   instruction image, IM0 at [DATA_W-1:0]
//   ins_valid  out  ins/pc valid to the datapath
//   ins_ready  in   datapath accepts the current word
//   ins        out  current instruction word
//   pc         out  index of ins within the image
//   busy       out  high while issuing
//   done       out  high after issue ends, until start or RST
//   halt_seen  out  issue ended on a HALT word
//   retired    out  words accepted since the last start

module ins_fetch_seq
    import fetch_pkg::*;
#(
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH  = FETCH_DEPTH,
    parameter int PC_W   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic                    start,
    input  logic [DEPTH*DATA_W-1:0] im_flat,
    output logic                    ins_valid,
    input  logic                    ins_ready,
    output logic [DATA_W-1:0]       ins,
    output logic [PC_W-1:0]         pc,
    output logic                    busy,
    output logic                    done,
    output logic                    halt_seen,
    output logic [PC_W:0]           retired
);

    localparam logic [PC_W-1:0]   LAST_PC = PC_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] HALT    = DATA_W'(HALT_WORD);

    state_t              state;
    state_t              state_nxt;
    logic                load;
    logic                accept;
    logic                is_halt;
    logic                at_last;
    logic                end_issue;
    logic [DATA_W-1:0]   buf_data;

    ins_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PC_W   (PC_W)
    ) u_buffer (
        .clk     (clk),
        .load    (load),
        .im_flat (im_flat),
        .rd_addr (pc),
        .rd_data (buf_data)
    );

    assign accept  = ins_valid && ins_ready;
    assign is_halt = (buf_data == HALT);
    assign at_last = (pc == LAST_PC);

`ifdef FETCH_LOOP_EN
    assign end_issue = is_halt;
`else
    assign end_issue = is_halt || at_last;
`endif

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                    load      = 1'b1;
                end
            end
            S_ISSUE: begin
                if (accept && end_issue) begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            pc        <= '0;
            retired   <= '0;
            halt_seen <= 1'b0;
        end else if (load) begin
            pc        <= '0;
            retired   <= '0;
            halt_seen <= 1'b0;
        end else if (accept) begin
`ifdef FETCH_LOOP_EN
            if (retired != '1) begin
                retired <= retired + (PC_W+1)'(1);
            end
`else
            retired <= retired + (PC_W+1)'(1);
`endif
            if (is_halt) begin
                halt_seen <= 1'b1;
            end else if (!at_last) begin
                pc <= pc + PC_W'(1);
            end else begin
`ifdef FETCH_LOOP_EN
                pc <= '0;
`else
                pc <= pc;
`endif
            end
        end
    end

    // The buffer has no reset, so ins is forced to zero until the first snapshot;
    // in DONE the buffer and pc are frozen, which holds the last word on ins.
    assign ins       = (state == S_IDLE) ? '0 : buf_data;
    assign ins_valid = (state == S_ISSUE);
    assign busy      = (state == S_ISSUE);
    assign done      = (state == S_DONE);

endmodule
